// File: rtl/alu_issue_decoder.sv
// RV32I integer-ALU issue decoder: decodes OP/OP-IMM/LUI/AUIPC into ALU control and operands, one-stage issue buffer.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid register so in_ready becomes a registered signal.
module alu_issue_decoder #(
  parameter int SIZE       = 32,
  parameter int XLEN_SHAMT = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [SIZE-1:0] in_pc,
  input  logic [SIZE-1:0] in_rs1_data,
  input  logic [SIZE-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_operand_1,
  output logic [SIZE-1:0] out_operand_2,
  output logic [4:0]      out_ALU_control,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal,
  output logic [SIZE-1:0] out_pc
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [SIZE-1:0] op1;
    logic [SIZE-1:0] op2;
    logic [4:0]      ctrl;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
    logic [SIZE-1:0] pc;
  } issue_t;

  issue_t          dec;
  issue_t          main_q;
  logic            out_valid_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_shift;
  logic            legal;
  logic            alt;
  logic [SIZE-1:0] imm_i;
  logic [SIZE-1:0] imm_u;
  logic [SIZE-1:0] shamt_r;
  logic [SIZE-1:0] shamt_i;
  logic [SIZE-1:0] op1;
  logic [SIZE-1:0] op2;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign imm_i    = SIZE'($signed(in_instr[31:20]));
  assign imm_u    = SIZE'($signed({in_instr[31:12], 12'b0}));
  assign shamt_r  = {{(SIZE-XLEN_SHAMT){1'b0}}, in_rs2_data[XLEN_SHAMT-1:0]};
  assign shamt_i  = {{(SIZE-XLEN_SHAMT){1'b0}}, in_instr[20 +: XLEN_SHAMT]};

  // Undecodable ops still flow through the buffer, with zeroed operands and no write-back.
  always_comb begin
    legal = 1'b0;
    alt   = 1'b0;
    op1   = '0;
    op2   = '0;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        alt   = in_instr[30];
        op1   = in_rs1_data;
        op2   = is_shift ? shamt_r : in_rs2_data;
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        alt = (funct3 == 3'b101) && in_instr[30];
        op1 = in_rs1_data;
        op2 = is_shift ? shamt_i : imm_i;
      end
      OPC_LUI: begin
        legal = 1'b1;
        op2   = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op1   = in_pc;
        op2   = imm_u;
      end
      default: legal = 1'b0;
    endcase

    dec         = '0;
    dec.rd      = in_instr[11:7];
    dec.pc      = in_pc;
    dec.illegal = !legal;
    if (legal) begin
      dec.op1 = op1;
      dec.op2 = op2;
      dec.wen = (in_instr[11:7] != 5'd0);
      if ((opcode == OPC_OP) || (opcode == OPC_OPIMM)) begin
        dec.ctrl = {funct3, alt, 1'b0};
      end
    end
  end

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_full_q;

  assign in_ready = !skid_full_q;

  // The skid entry is always older than any new op, so it refills the main buffer first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_full_q) begin
        main_q      <= skid_q;
        out_valid_q <= 1'b1;
        skid_full_q <= 1'b0;
      end else if (in_valid) begin
        main_q      <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && !skid_full_q) begin
      skid_q      <= dec;
      skid_full_q <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      main_q      <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid       = out_valid_q;
  assign out_operand_1   = main_q.op1;
  assign out_operand_2   = main_q.op2;
  assign out_ALU_control = main_q.ctrl;
  assign out_rd          = main_q.rd;
  assign out_wen         = main_q.wen;
  assign out_illegal     = main_q.illegal;
  assign out_pc          = main_q.pc;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: directed cases then randomized traffic with flush and reset.
module tb_alu_issue_decoder;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand_1;
  logic [31:0] out_operand_2;
  logic [4:0]  out_ALU_control;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic [31:0] out_pc;

  alu_issue_decoder #(.SIZE(32), .XLEN_SHAMT(5)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_operand_1   (out_operand_1),
    .out_operand_2   (out_operand_2),
    .out_ALU_control (out_ALU_control),
    .out_rd          (out_rd),
    .out_wen         (out_wen),
    .out_illegal     (out_illegal),
    .out_pc          (out_pc)
  );

  typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND, M_ILL} mn_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] code_of(input mn_t m);
    case (m)
      M_ADD:   return 5'b00000;
      M_SUB:   return 5'b00010;
      M_SLL:   return 5'b00100;
      M_SLT:   return 5'b01000;
      M_SLTU:  return 5'b01100;
      M_XOR:   return 5'b10000;
      M_SRL:   return 5'b10100;
      M_SRA:   return 5'b10110;
      M_OR:    return 5'b11000;
      M_AND:   return 5'b11100;
      default: return 5'b00000;
    endcase
  endfunction

  // Reference: name the instruction first, then derive code and operands from the mnemonic.
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    mn_t        m;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       shift;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    m   = M_ILL;
    e   = '0;
    e.rd = instr[11:7];
    e.pc = pc;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: m = M_ADD;  3'd1: m = M_SLL; 3'd2: m = M_SLT; 3'd3: m = M_SLTU;
          3'd4: m = M_XOR;  3'd5: m = M_SRL; 3'd6: m = M_OR;  default: m = M_AND;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) m = M_SRA;
      shift = (m == M_SLL) || (m == M_SRL) || (m == M_SRA);
      e.op1 = a;
      e.op2 = shift ? (b % 32) : b;
    end else if (opc == 7'h13) begin
      case (f3)
        3'd0: m = M_ADD;
        3'd1: m = (f7 == 7'h00) ? M_SLL : M_ILL;
        3'd2: m = M_SLT;
        3'd3: m = M_SLTU;
        3'd4: m = M_XOR;
        3'd5: m = (f7 == 7'h00) ? M_SRL : ((f7 == 7'h20) ? M_SRA : M_ILL);
        3'd6: m = M_OR;
        default: m = M_AND;
      endcase
      shift = (m == M_SLL) || (m == M_SRL) || (m == M_SRA);
      e.op1 = a;
      e.op2 = shift ? ((instr >> 20) % 32) : 32'($signed(instr) >>> 20);
    end else if (opc == 7'h37) begin
      m = M_ADD;
      e.op2 = instr & 32'hFFFF_F000;
    end else if (opc == 7'h17) begin
      m = M_ADD;
      e.op1 = pc;
      e.op2 = instr & 32'hFFFF_F000;
    end
    e.ctrl = code_of(m);
    e.ill  = (m == M_ILL);
    e.wen  = !e.ill && (e.rd != 5'd0);
    if (e.ill) begin
      e.op1 = '0;
      e.op2 = '0;
    end
    return e;
  endfunction

  function automatic logic [6:0] rand_funct7();
    case ($urandom_range(0, 3))
      0, 1:    return 7'h00;
      2:       return 7'h20;
      default: return 7'($urandom());
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if (k <= 3) begin
      w[6:0]   = 7'h33;
      w[31:25] = rand_funct7();
    end else if (k <= 6) begin
      w[6:0] = 7'h13;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = rand_funct7();
    end else if (k == 7) begin
      w[6:0] = 7'h37;
    end else if (k == 8) begin
      w[6:0] = 7'h17;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive at +1 after the edge, record the handshake outcome at +4.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic ordy, input logic fl, input logic rstn);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    out_ready   = ordy;
    flush       = fl;
    reset_n     = rstn;
    #3;
    if (!reset_n || flush) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
  endtask

  // Monitor: at +3 after each edge compare the presented op with the oldest expected one.
  initial begin : monitor
    logic rst_edge;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_edge = reset_n;
      #3;
      if (!rst_edge) begin
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_operand_1", out_operand_1, 32'd0);
        checkOutput("reset_operand_2", out_operand_2, 32'd0);
        checkOutput("reset_ctrl", 32'(out_ALU_control), 32'd0);
        checkOutput("reset_rd", 32'(out_rd), 32'd0);
        checkOutput("reset_wen", 32'(out_wen), 32'd0);
        checkOutput("reset_illegal", 32'(out_illegal), 32'd0);
        checkOutput("reset_pc", out_pc, 32'd0);
      end else begin
        checkOutput("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      end
`ifdef ALU_ISSUE_SKID_EN
      checkOutput("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
`else
      checkOutput("in_ready", 32'(in_ready), 32'((sb_q.size() == 0) || out_ready));
`endif
      if (rst_edge && out_valid && sb_q.size() > 0) begin
        e = sb_q[0];
        checkOutput("operand_1", out_operand_1, e.op1);
        checkOutput("operand_2", out_operand_2, e.op2);
        checkOutput("alu_control", 32'(out_ALU_control), 32'(e.ctrl));
        checkOutput("rd", 32'(out_rd), 32'(e.rd));
        checkOutput("wen", 32'(out_wen), 32'(e.wen));
        checkOutput("illegal", 32'(out_illegal), 32'(e.ill));
        checkOutput("pc", out_pc, e.pc);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    int waited;
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_pc       = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready   = 1'b0;
    $display("[TB] start");

    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 0);

    applyStimulus(1, 32'h002081B3, 32'h00, 5, 7, 1, 0, 1);
    applyStimulus(1, 32'h402081B3, 32'h04, 5, 7, 1, 0, 1);
    applyStimulus(1, 32'h40335293, 32'h08, 32'h80000000, 0, 1, 0, 1);
    applyStimulus(1, 32'h002091B3, 32'h0C, 9, 32'hFFFFFF21, 1, 0, 1);
    applyStimulus(1, 32'hFFF00093, 32'h10, 3, 4, 1, 0, 1);
    applyStimulus(1, 32'h123450B7, 32'h14, 3, 4, 1, 0, 1);
    applyStimulus(1, 32'h00000097, 32'h100, 3, 4, 1, 0, 1);
    applyStimulus(1, 32'h40309093, 32'h18, 3, 4, 1, 0, 1);
    applyStimulus(1, 32'h00002083, 32'h1C, 3, 4, 1, 0, 1);
    applyStimulus(1, 32'h00208033, 32'h20, 3, 4, 1, 0, 1);

    applyStimulus(1, 32'h002081B3, 32'h24, 11, 22, 0, 0, 1);
    applyStimulus(1, 32'h402081B3, 32'h28, 11, 22, 0, 0, 1);
    applyStimulus(1, 32'h0020C1B3, 32'h2C, 11, 22, 0, 0, 1);
    applyStimulus(1, 32'h0020E1B3, 32'h30, 11, 22, 1, 0, 1);
    applyStimulus(1, 32'h0020F1B3, 32'h34, 11, 22, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);

    applyStimulus(1, 32'h002081B3, 32'h40, 1, 2, 0, 0, 1);
    applyStimulus(1, 32'h402081B3, 32'h44, 1, 2, 0, 1, 1);
    applyStimulus(1, 32'h002081B3, 32'h48, 6, 2, 0, 0, 1);
    applyStimulus(1, 32'h002081B3, 32'h4C, 7, 2, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom(), $urandom(),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, i != 200);
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
      waited++;
    end
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1, 0, 1);
    checkOutput("drain_pending", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
